// File: rtl/tube_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tube_fifo : parasite-to-host first-word-fall-through FIFO with sticky flags
// Revision  : 1.0
// ---------------------------------------------------------------------------
module tube_fifo #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 24,
  parameter logic [WIDTH-1:0] EMPTY_VALUE = WIDTH'(8'hAA),
  localparam int              LW          = $clog2(DEPTH + 1)
) (
  input  logic             h_phi2,
  input  logic             h_rst_b,
  input  logic [WIDTH-1:0] p_data,
  input  logic             p_selectData,
  input  logic             p_rdnw,
  input  logic             h_selectData,
  input  logic             h_rd,
  input  logic             mode2,
  input  logic             flush,
  output logic [WIDTH-1:0] h_data,
  output logic             h_data_available,
  output logic             p_full,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_req;
  logic             w_rd_req;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  assign w_wr_req = p_selectData & ~p_rdnw;
  assign w_rd_req = h_selectData & h_rd;
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(DEPTH));

  // Acceptance depends only on the pre-edge level, so a full FIFO takes the
  // read and refuses the write, and an empty one does the opposite.
  assign w_wr_ok  = w_wr_req & ~w_full;
  assign w_rd_ok  = w_rd_req & ~w_empty;

  // DEPTH need not be a power of two, so wrap explicitly.
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_ok) r_rd_ptr <= w_rd_ptr_nxt;
      if (w_wr_ok && !w_rd_ok)      r_level <= r_level + LW'(1);
      else if (w_rd_ok && !w_wr_ok) r_level <= r_level - LW'(1);
      if (w_wr_req && !w_wr_ok) r_overflow  <= 1'b1;
      if (w_rd_req && !w_rd_ok) r_underflow <= 1'b1;
    end
  end

  // Storage carries no reset; stale entries are masked while level is zero.
  always_ff @(posedge h_phi2) begin
    if (w_wr_ok && !flush) r_mem[r_wr_ptr] <= p_data;
  end

  assign h_data           = w_empty ? EMPTY_VALUE : r_mem[r_rd_ptr];
  assign h_data_available = mode2 ? (r_level >= LW'(2)) : ~w_empty;
  assign p_full           = w_full;
  assign level            = r_level;
  assign overflow         = r_overflow;
  assign underflow        = r_underflow;

endmodule
`default_nettype wire
